// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the idle line level, common to TX and RX.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset value.
module uart_sync #(
  parameter int unsigned       Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_meta;
  logic [Width-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= ResetVal;
      r_sync <= ResetVal;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (start, SIZE data bits LSB first, stop) with valid/ack holding register.
// Optional stop-bit check and FRAME_ERR port: define UART_RX_FRAME_CHECK_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic            i_rxc,
  input  logic            i_rst_n,
  input  logic            i_rxd,
  input  logic            i_rx_ack,
  output logic [SIZE-1:0] o_rxdata,
  output logic            o_rx_valid,
  output logic            o_rx_busy,
  output logic            o_rx_overrun
`ifdef UART_RX_FRAME_CHECK_EN
  ,
  output logic            o_frame_err
`endif
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW = $clog2(SIZE) + 1;
  localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(OVERSAMPLE - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(SIZE - 1);

  rx_state_t       r_state;
  logic [CntW-1:0] r_cnt;
  logic [IdxW-1:0] r_idx;
  logic [SIZE-1:0] r_shift;
  logic            r_armed;
  logic [SIZE-1:0] r_rxdata;
  logic            r_valid;
  logic            r_busy;
  logic            r_overrun;
`ifdef UART_RX_FRAME_CHECK_EN
  logic            r_frame_err;
`endif

  logic w_line;
  logic w_stop_done;
  logic w_stop_ok;
  logic w_deliver;
  logic w_ack_take;

  uart_sync #(
    .Width    (1),
    .ResetVal (IDLE_LEVEL)
  ) u_sync (
    .i_clk   (i_rxc),
    .i_rst_n (i_rst_n),
    .i_d     (i_rxd),
    .o_q     (w_line)
  );

  assign w_stop_done = (r_state == STOP) && (r_cnt == CntFull);
`ifdef UART_RX_FRAME_CHECK_EN
  assign w_stop_ok   = (w_line == IDLE_LEVEL);
`else
  assign w_stop_ok   = 1'b1;
`endif
  assign w_deliver   = w_stop_done && w_stop_ok;
  assign w_ack_take  = i_rx_ack && r_valid;

  always_ff @(posedge i_rxc or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_armed   <= 1'b0;
      r_rxdata  <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
      r_frame_err <= 1'b0;
`endif
    end else begin
`ifdef UART_RX_FRAME_CHECK_EN
      r_frame_err <= 1'b0;
`endif
      // A same-cycle ack frees the holding register for the incoming word.
      if (w_deliver) begin
        if (!r_valid || i_rx_ack) begin
          r_rxdata <= r_shift;
          r_valid  <= 1'b1;
          if (w_ack_take) begin
            r_overrun <= 1'b0;
          end
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_ack_take) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (r_armed && (w_line != IDLE_LEVEL)) begin
            r_state <= START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else if (w_line == IDLE_LEVEL) begin
            r_armed <= 1'b1;
          end
        end
        START: begin
          if (r_cnt == CntHalf) begin
            if (w_line == IDLE_LEVEL) begin
              // Glitch: start bit vanished before mid-bit; stay armed.
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= DATA;
              r_cnt   <= '0;
              r_idx   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == CntFull) begin
            r_shift <= {w_line, r_shift[SIZE-1:1]};
            r_cnt   <= '0;
            if (r_idx == IdxLast) begin
              r_state <= STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == CntFull) begin
            // Disarm so a held-low line (break) cannot start a new frame.
            r_state <= IDLE;
            r_cnt   <= '0;
            r_armed <= 1'b0;
            r_busy  <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
            if (w_line != IDLE_LEVEL) begin
              r_frame_err <= 1'b1;
            end
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rxdata     = r_rxdata;
  assign o_rx_valid   = r_valid;
  assign o_rx_busy    = r_busy;
  assign o_rx_overrun = r_overrun;
`ifdef UART_RX_FRAME_CHECK_EN
  assign o_frame_err  = r_frame_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: loopback, glitch, overrun, same-cycle ack, break, mid-frame reset.
module tb_uart_rx;

  localparam int unsigned Bit = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd   = 1'b1;
  logic       ack   = 1'b0;
  logic [7:0] rxdata;
  logic       valid;
  logic       busy;
  logic       overrun;
`ifdef UART_RX_FRAME_CHECK_EN
  logic       ferr;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  uart_rx #(
    .SIZE       (8),
    .OVERSAMPLE (16)
  ) dut (
    .i_rxc        (clk),
    .i_rst_n      (rst_n),
    .i_rxd        (rxd),
    .i_rx_ack     (ack),
    .o_rxdata     (rxdata),
    .o_rx_valid   (valid),
    .o_rx_busy    (busy),
    .o_rx_overrun (overrun)
`ifdef UART_RX_FRAME_CHECK_EN
    ,
    .o_frame_err  (ferr)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    tick(Bit);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      tick(Bit);
    end
    rxd = stop;
    tick(Bit);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int nrise;
    int ferr_cnt;
    bit ok;
    bit pv;

    #3;
    check("rst_rxdata", rxdata, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
`ifdef UART_RX_FRAME_CHECK_EN
    check("rst_ferr", ferr, 1'b0);
`endif
    tick(3);
    rst_n = 1'b1;
    tick(5);

    // Loopback: AA then CC back-to-back, ack one cycle after each valid.
    t0 = cyc + 1;
    fork
      begin
        send_byte(8'hAA, 1'b1);
        send_byte(8'hCC, 1'b1);
      end
      begin
        wait_valid(400, ok);
        check("lb_wait0", ok, 1'b1);
        check("lb_lat0", cyc, t0 + 154);
        check("lb_data0", rxdata, 8'hAA);
        check("lb_busy_fall", busy, 1'b0);
        tick(1);
        pulse_ack();
        check("lb_valid_clr0", valid, 1'b0);
        wait_valid(400, ok);
        check("lb_wait1", ok, 1'b1);
        check("lb_lat1", cyc, t0 + 314);
        check("lb_data1", rxdata, 8'hCC);
        tick(1);
        pulse_ack();
        check("lb_valid_clr1", valid, 1'b0);
        check("lb_overrun", overrun, 1'b0);
      end
    join
    tick(8);

    // Glitch: 4 cycles low enters START, then drops back to IDLE.
    rxd = 1'b0;
    tick(4);
    check("gl_busy_start", busy, 1'b1);
    rxd = 1'b1;
    tick(20);
    check("gl_busy_idle", busy, 1'b0);
    check("gl_valid", valid, 1'b0);
    fork
      send_byte(8'h5A, 1'b1);
      begin
        wait_valid(400, ok);
        check("gl_wait", ok, 1'b1);
        check("gl_data", rxdata, 8'h5A);
      end
    join
    pulse_ack();
    tick(8);

    // Overrun: two words, no ack.
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    tick(4);
    check("ov_data", rxdata, 8'h11);
    check("ov_valid", valid, 1'b1);
    check("ov_overrun", overrun, 1'b1);
    pulse_ack();
    check("ov_valid_clr", valid, 1'b0);
    check("ov_overrun_clr", overrun, 1'b0);
    tick(8);

    // Same-cycle ack on the delivery edge of the second word.
    send_byte(8'h44, 1'b1);
    check("sc_data0", rxdata, 8'h44);
    check("sc_valid0", valid, 1'b1);
    t0 = cyc + 1;
    fork
      send_byte(8'h33, 1'b1);
      begin
        tick(154);
        check("sc_pre_data", rxdata, 8'h44);
        check("sc_pre_cyc", cyc, t0 + 153);
        pulse_ack();
        check("sc_data1", rxdata, 8'h33);
        check("sc_valid1", valid, 1'b1);
        check("sc_overrun", overrun, 1'b0);
      end
    join
    pulse_ack();
    check("sc_valid_clr", valid, 1'b0);
    tick(8);

    // Break: F0 with low stop bit, line held low 40 bit times, then idle.
    nrise    = 0;
    ferr_cnt = 0;
    fork
      begin
        send_byte(8'hF0, 1'b0);
        tick(40 * Bit);
        rxd = 1'b1;
        tick(2 * Bit);
      end
      begin
        pv = valid;
        for (int i = 0; i < (10 + 40 + 2) * Bit - 2; i++) begin
          @(negedge clk);
          if (valid && !pv) nrise++;
          pv = valid;
`ifdef UART_RX_FRAME_CHECK_EN
          if (ferr) ferr_cnt++;
`endif
        end
      end
    join
    check("brk_busy", busy, 1'b0);
`ifdef UART_RX_FRAME_CHECK_EN
    check("brk_ferr_pulses", ferr_cnt, 1);
    check("brk_rises", nrise, 0);
    check("brk_valid", valid, 1'b0);
`else
    check("brk_rises", nrise, 1);
    check("brk_data", rxdata, 8'hF0);
    pulse_ack();
`endif
    fork
      send_byte(8'h0F, 1'b1);
      begin
        wait_valid(400, ok);
        check("brk_wait", ok, 1'b1);
        check("brk_next", rxdata, 8'h0F);
      end
    join
    tick(8);

    // Mid-frame reset during data bit 4 of 96; 0F left unacked so the clear is visible.
    fork
      send_byte(8'h96, 1'b1);
      begin
        tick(85);
        check("mr_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mr_rxdata", rxdata, 8'h00);
        check("mr_valid", valid, 1'b0);
        check("mr_busy_clr", busy, 1'b0);
        check("mr_overrun", overrun, 1'b0);
      end
    join
    tick(5);
    rst_n = 1'b1;
    tick(5);
    check("mr_valid_post", valid, 1'b0);
    fork
      send_byte(8'h69, 1'b1);
      begin
        wait_valid(400, ok);
        check("mr_wait", ok, 1'b1);
        check("mr_data", rxdata, 8'h69);
        check("mr_overrun_post", overrun, 1'b0);
      end
    join
    pulse_ack();
    check("mr_valid_clr", valid, 1'b0);
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
